ps2_key_matrix: RTL and testbench
=================================

# ps2_key_matrix

Parametrised PS/2-to-keyboard-matrix converter for retro-console cores: consumes the `ps2_key` event word from `hps_io` and presents an active-low column response to the core's row strobes. It generalises fixed per-core keyboard decoders with a runtime-loadable key map, a configurable matrix size, lock (toggle) keys, guaranteed minimum key hold and merged external (joystick) inputs. It sits between `hps_io` and the console core's GPIO/keyboard port, all on `clk_sys`.

## Interface
- `ROWS`, 8, number of row strobes (1..16)
- `COLS`, 8, number of column returns (1..16)
- `HOLD_CYCLES`, 16384, hold-timer period in clocks (≥2)
- Derived: `IW = $clog2(ROWS*COLS)`; map entry width `MW = IW+2`
- `clk_sys  in  1  system clock`
- `reset  in  1  synchronous, active-high reset`
- `ps2_key  in  11  [10] toggle-per-event, [9] pressed, [8] extended, [7:0] scancode`
- `clear_i  in  1  force all keys released, lock keys off (e.g. during download)`
- `map_wr_i  in  1  map write strobe`
- `map_addr_i  in  9  map address = {extended, scancode}`
- `map_data_i  in  MW  [MW-1] valid, [MW-2] lock, [IW-1:0] key index = row*COLS+col`
- `ext_keys_i  in  ROWS*COLS  external key bits (joystick), active-high, ORed per index`
- `row_sel_n_i  in  ROWS  row strobes, active-low, any number asserted`
- `col_n_o  out  COLS  column returns, active-low, registered`
- `lock_o  out  ROWS*COLS  current key-state vector (debug/LED)`

## Operation
- Event detect: register `ps2_key[10]`; event when it differs from the stored copy. First cycle after reset captures without generating an event.
- Stage 1 (event cycle T): map RAM read at `ps2_key[8:0]`; latch `pressed`.
- Stage 2 (T+1): entry available. Invalid entry → event dropped. Index ≥ ROWS*COLS → dropped.
- Normal key: press → state bit set, pending-release bits cleared; release → pending stage A set.
- Lock key: press → state bit inverted; release ignored.
- Hold timer: free-running counter 0..HOLD_CYCLES-1, `tick` at wrap. On tick: keys with stage B set → state cleared, stage B cleared; stage A moved to stage B. Guarantees held ≥ HOLD_CYCLES clocks, released ≤ 2·HOLD_CYCLES after break.
- Same key event and tick in same cycle: event wins for that key; other keys tick normally.
- Map write: RAM written on `map_wr_i`; concurrent lookup at same address returns old data (read-before-write).
- Column: `col_n_o[c] = ~|{ r : ~row_sel_n_i[r] & (state[r*COLS+c] | ext_keys_i[r*COLS+c]) }`.
- `clear_i` / `reset`: state, pending A/B, lock states → 0; event-detect copy reloaded from `ps2_key[10]`; in-flight stage-2 event discarded. Timer reset to 0 (reset only). Map contents unaffected by either.

## Timing
- Reset values: `col_n_o` all 1, `lock_o` all 0.
- Press: toggle seen at T → state bit visible on `lock_o` at T+2 → `col_n_o` at T+3.
- Row/ext change → `col_n_o` one clock later.
- Back-to-back events on consecutive cycles fully supported (1 event/clock throughput).
- `clear_i` takes effect at next edge; `col_n_o` all 1 one clock later if `ext_keys_i` = 0.

## Structure
- Package `ps2_matrix_pkg`: map entry struct (valid, lock, index), `EVT_*` field positions of `ps2_key`, default `HOLD_CYCLES`.
- Sub-module `key_map_ram`: 512×MW synchronous-read RAM, one write and one read port, read-before-write; inferred block RAM.
- Top: event detect, 2-stage pipeline, state/pending vectors, timer, column reduction.

## Test plan
- Map 0x01C→{valid,idx 0x2B}; press `A` (toggle, pressed=1, code 0x1C); drive row 5 low → `col_n_o` = 8'hF7 at T+3; other rows → 8'hFF.
- Release `A` 3 clocks after press, HOLD_CYCLES=16 → column stays low ≥16 clocks, returns 8'hFF within 32 clocks of break.
- Lock key 0x058→{valid,lock,idx 0x20}: press/release → bit set; second press/release → cleared; releases never change state.
- Re-press normal key during pending release → remains held through two further ticks without any glitch on `col_n_o`.
- `ext_keys_i[0]`=1 with row 0 low → `col_n_o`[0]=0 next clock; assert `clear_i` with 3 keys held → only ext bit remains low; unmapped code 0x17A event → no change.
- Map write at same address and cycle as event → old mapping applied; next event uses new mapping; reset mid-pipeline (T+1) → no state change after reset.

Source files
------------

// File: rtl/ps2_matrix_pkg.sv
// ps2_key_matrix shared types and constants.
// Map entry layout and ps2_key event-word fields.
package ps2_matrix_pkg;

  localparam int HOLD_DEFAULT = 16384;

  localparam int EVT_TOGGLE  = 10;
  localparam int EVT_PRESSED = 9;
  localparam int EVT_EXT     = 8;

  localparam int IDX_W = 8;

  typedef struct packed {
    logic             valid;
    logic             lock;
    logic [IDX_W-1:0] index;
  } map_entry_t;

endpackage

// File: rtl/ps2_key_map_ram.sv
// Scancode-to-matrix map storage, 512 entries.
// Synchronous read, old data on same-address write.
module key_map_ram #(
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [8:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [8:0]    raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [512];

  // write and registered read share one edge
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 event word to active-low key matrix.
// Runtime key map, lock keys, minimum hold.
module ps2_key_matrix
  import ps2_matrix_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  localparam int N  = ROWS * COLS,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int MW = IW + 2
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [10:0]     ps2_key,
  input  logic            clear_i,
  input  logic            map_wr_i,
  input  logic [8:0]      map_addr_i,
  input  logic [MW-1:0]   map_data_i,
  input  logic [N-1:0]    ext_keys_i,
  input  logic [ROWS-1:0] row_sel_n_i,
  output logic [COLS-1:0] col_n_o,
  output logic [N-1:0]    lock_o
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic          tog_q;
  logic          init_q;
  logic          evt;
  logic          s1_vld;
  logic          s1_pressed;
  logic [MW-1:0] rd;
  map_entry_t    ent;
  logic [IW-1:0] kidx;
  logic          hit;
  logic          lk_press;
  logic          nk_press;
  logic          nk_rel;
  logic [TW-1:0] cnt;
  logic          tick;
  logic [N-1:0]  state_q, state_d;
  logic [N-1:0]  pa_q, pa_d;
  logic [N-1:0]  pb_q, pb_d;
  logic [COLS-1:0] col_d;

  key_map_ram #(.DW(MW)) u_map (
    .clk_sys (clk_sys),
    .we      (map_wr_i),
    .waddr   (map_addr_i),
    .wdata   (map_data_i),
    .raddr   (ps2_key[EVT_EXT:0]),
    .rdata   (rd)
  );

  assign evt = init_q & (ps2_key[EVT_TOGGLE] != tog_q)
             & ~clear_i & ~reset;

  // event detect and stage-1 capture
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[EVT_TOGGLE];
    if (reset) begin
      init_q     <= 1'b0;
      s1_vld     <= 1'b0;
      s1_pressed <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      s1_vld     <= evt;
      s1_pressed <= ps2_key[EVT_PRESSED];
    end
  end

  // hold timer, tick on wrap
  always_ff @(posedge clk_sys) begin
    if (reset || tick) cnt <= '0;
    else               cnt <= cnt + TW'(1);
  end

  assign tick = (cnt == TW'(HOLD_CYCLES - 1));

  // unpack the map entry returned for stage 2
  always_comb begin
    ent.valid = rd[MW-1];
    ent.lock  = rd[MW-2];
    ent.index = IDX_W'(rd[IW-1:0]);
  end

  assign kidx     = ent.index[IW-1:0];
  assign hit      = s1_vld & ent.valid
                  & ({1'b0, ent.index} < 9'(N));
  assign lk_press = hit &  ent.lock &  s1_pressed;
  assign nk_press = hit & ~ent.lock &  s1_pressed;
  assign nk_rel   = hit & ~ent.lock & ~s1_pressed;

  // key state: tick ages releases, event overrides its key
  always_comb begin
    state_d = state_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    if (tick) begin
      state_d = state_q & ~pb_q;
      pb_d    = pa_q;
      pa_d    = '0;
    end
    unique case (1'b1)
      lk_press: begin
        state_d[kidx] = ~state_q[kidx];
        pa_d[kidx]    = pa_q[kidx];
        pb_d[kidx]    = pb_q[kidx];
      end
      nk_press: begin
        state_d[kidx] = 1'b1;
        pa_d[kidx]    = 1'b0;
        pb_d[kidx]    = 1'b0;
      end
      nk_rel: begin
        state_d[kidx] = state_q[kidx];
        pa_d[kidx]    = 1'b1;
        pb_d[kidx]    = pb_q[kidx];
      end
      default: ;
    endcase
  end

  // state and pending-release registers
  always_ff @(posedge clk_sys) begin
    if (reset || clear_i) begin
      state_q <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
    end
  end

  // column reduction over asserted rows
  always_comb begin
    col_d = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!row_sel_n_i[r] &&
            (state_q[r*COLS+c] || ext_keys_i[r*COLS+c]))
          col_d[c] = 1'b0;
      end
    end
  end

  // registered column returns
  always_ff @(posedge clk_sys) begin
    if (reset) col_n_o <= '1;
    else       col_n_o <= col_d;
  end

  assign lock_o = state_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Bench for ps2_key_matrix: vector table plus
// latency scoreboard and multi-cycle sequences.
module tb_ps2_key_matrix;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = 64;
  localparam int HOLD = 16;
  localparam int MW   = 8;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic [10:0]     ps2_key;
  logic            clear_i;
  logic            map_wr_i;
  logic [8:0]      map_addr_i;
  logic [MW-1:0]   map_data_i;
  logic [N-1:0]    ext_keys_i;
  logic [ROWS-1:0] row_sel_n_i;
  logic [COLS-1:0] col_n_o;
  logic [N-1:0]    lock_o;

  ps2_key_matrix #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .clear_i     (clear_i),
    .map_wr_i    (map_wr_i),
    .map_addr_i  (map_addr_i),
    .map_data_i  (map_data_i),
    .ext_keys_i  (ext_keys_i),
    .row_sel_n_i (row_sel_n_i),
    .col_n_o     (col_n_o),
    .lock_o      (lock_o)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [7:0]  rows_n;
    logic [63:0] ext;
    logic [7:0]  col;
  } vec_t;

  vec_t vt[9];

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic expect_col(int d, logic [7:0] v, string nm);
    sbq.push_back('{cyc + d, 0, 0, 64'(v), nm});
  endtask

  task automatic expect_bit(int d, int i, logic v, string nm);
    sbq.push_back('{cyc + d, 1, i, 64'(v), nm});
  endtask

  task automatic expect_vec(int d, logic [63:0] v, string nm);
    sbq.push_back('{cyc + d, 2, 0, v, nm});
  endtask

  task automatic send_evt(logic pr, logic [8:0] a);
    ps2_key = {~ps2_key[10], pr, a};
  endtask

  task automatic map_write(logic [8:0] a, logic [7:0] d);
    map_wr_i   = 1'b1;
    map_addr_i = a;
    map_data_i = d;
    step();
    map_wr_i   = 1'b0;
  endtask

  // scoreboard: compare due entries away from the active edge
  always @(negedge clk_sys) begin
    exp_t        e;
    logic [63:0] got;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        e = sbq[i];
        unique case (e.kind)
          0:       got = 64'(col_n_o);
          1:       got = 64'(lock_o[e.idx]);
          default: got = lock_o;
        endcase
        checks++;
        if (e.due != cyc || got !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h (due %0d at %0d)",
                   e.name, got, e.val, e.due, cyc);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    int bad;
    int w;

    vt[0] = '{8'hFF, 64'h0, 8'hFF};
    vt[1] = '{8'hDF, 64'h0, 8'hF7};
    vt[2] = '{8'hEF, 64'h0, 8'hFE};
    vt[3] = '{8'hCF, 64'h0, 8'hF6};
    vt[4] = '{8'hF0, 64'h0, 8'hFF};
    vt[5] = '{8'h00, 64'h0, 8'hF6};
    vt[6] = '{8'hFE, 64'h1, 8'hFE};
    vt[7] = '{8'h7F, 64'h1 << 63, 8'h7F};
    vt[8] = '{8'hFF, 64'h200, 8'hFF};

    reset       = 1'b1;
    ps2_key     = '0;
    clear_i     = 1'b0;
    map_wr_i    = 1'b0;
    map_addr_i  = '0;
    map_data_i  = '0;
    ext_keys_i  = '0;
    row_sel_n_i = '1;
    step(3);
    chk("reset_col", 64'(col_n_o), 64'hFF);
    chk("reset_lock", lock_o, 64'h0);
    reset = 1'b0;
    step(2);

    map_write(9'h01C, 8'hAB);
    map_write(9'h058, 8'hE0);
    map_write(9'h032, 8'h89);
    map_write(9'h021, 8'h92);
    map_write(9'h17A, 8'h00);

    row_sel_n_i = 8'hDF;
    send_evt(1'b1, 9'h01C);
    expect_bit(2, 43, 1'b1, "a_press_lock");
    expect_col(2, 8'hFF, "a_press_early");
    expect_col(3, 8'hF7, "a_press_col");
    step(3);
    send_evt(1'b0, 9'h01C);
    low_cnt = 0;
    for (int i = 0; i < HOLD; i++) begin
      if (col_n_o === 8'hF7) low_cnt++;
      step();
    end
    chk("hold_min", 64'(low_cnt), 64'(HOLD));
    w = HOLD;
    while (col_n_o !== 8'hFF && w < 2 * HOLD + 4) begin
      step();
      w++;
    end
    chk("release_within", 64'(col_n_o), 64'hFF);

    row_sel_n_i = 8'hEF;
    send_evt(1'b1, 9'h058);
    expect_bit(2, 32, 1'b1, "lock_on");
    expect_col(3, 8'hFE, "lock_on_col");
    step(4);
    send_evt(1'b0, 9'h058);
    step(2 * HOLD + 4);
    chk("lock_rel_keep", 64'(lock_o[32]), 64'h1);
    send_evt(1'b1, 9'h058);
    expect_bit(2, 32, 1'b0, "lock_off");
    step(4);
    send_evt(1'b0, 9'h058);
    step(2 * HOLD + 4);
    chk("lock_rel_off", lock_o, 64'h0);
    chk("lock_off_col", 64'(col_n_o), 64'hFF);

    send_evt(1'b1, 9'h058);
    step();
    send_evt(1'b1, 9'h01C);
    expect_vec(2, (64'h1 << 43) | (64'h1 << 32), "b2b_vec");
    step(3);

    for (int i = 0; i < 9; i++) begin
      row_sel_n_i = vt[i].rows_n;
      ext_keys_i  = vt[i].ext;
      expect_col(1, vt[i].col, $sformatf("vec%0d", i));
      step();
    end
    ext_keys_i = '0;

    row_sel_n_i = 8'hFD;
    send_evt(1'b1, 9'h032);
    step(4);
    send_evt(1'b0, 9'h032);
    step(2);
    send_evt(1'b1, 9'h032);
    bad = 0;
    for (int i = 0; i < 2 * HOLD + 8; i++) begin
      if (col_n_o !== 8'hFD) bad++;
      step();
    end
    chk("repress_glitch", 64'(bad), 64'h0);
    chk("repress_held", 64'(lock_o[9]), 64'h1);

    ext_keys_i  = 64'h1;
    row_sel_n_i = 8'h00;
    step();
    chk("pre_clear", 64'(col_n_o), 64'hF4);
    clear_i = 1'b1;
    expect_vec(1, 64'h0, "clear_lock");
    expect_col(2, 8'hFE, "clear_col");
    step();
    clear_i = 1'b0;
    step(3);

    send_evt(1'b1, 9'h17A);
    expect_vec(2, 64'h0, "unmapped_lock");
    expect_col(3, 8'hFE, "unmapped_col");
    step(4);
    ext_keys_i = '0;

    send_evt(1'b1, 9'h01C);
    map_wr_i   = 1'b1;
    map_addr_i = 9'h01C;
    map_data_i = 8'hBF;
    expect_bit(2, 43, 1'b1, "rbw_old");
    expect_bit(2, 63, 1'b0, "rbw_not_new");
    step();
    map_wr_i = 1'b0;
    step(3);
    send_evt(1'b1, 9'h01C);
    expect_vec(2, (64'h1 << 43) | (64'h1 << 63), "rbw_new");
    step(4);

    send_evt(1'b1, 9'h032);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(4);
    chk("reset_mid_lock", lock_o, 64'h0);
    chk("reset_mid_col", 64'(col_n_o), 64'hFF);

    send_evt(1'b1, 9'h021);
    expect_vec(2, 64'h1 << 18, "post_reset_evt");
    expect_col(3, 8'hFB, "post_reset_col");
    step(5);

    w = 0;
    while (sbq.size() != 0 && w < 100) begin
      step();
      w++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0",
               sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
